spi_master_modes: RTL and testbench
===================================

SPI_MASTER_MODES -- requirements
Module: spi_master_modes

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the bits per transfer (legal range 4..32).
REQ-002 Parameter NUM_CS, default 4, SHALL set the number of chip-select outputs (legal range 1..8).
REQ-003 Parameter DIV_W, default 8, SHALL set the width of the clock-divider input.
REQ-004 clk  in  1  SHALL be the system clock; all logic is on the rising edge.
REQ-005 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 start  in  1  SHALL request a transfer; it is accepted only when busy=0.
REQ-007 data_in  in  DATA_W  SHALL be the transmit word.
REQ-008 cs_sel  in  max(1,$clog2(NUM_CS))  SHALL select the target slave.
REQ-009 cpol  in  1  SHALL set the SCK idle level.
REQ-010 cpha  in  1  SHALL set the sample phase: 0 = sample on the leading edge, 1 = sample on the trailing edge.
REQ-011 lsb_first  in  1  SHALL set bit order: 1 = LSB first, 0 = MSB first.
REQ-012 clk_div  in  DIV_W  SHALL set the SCK half-period to H = clk_div+1 clk cycles.
REQ-013 miso  in  1  SHALL be the serial data input from the slave.
REQ-014 mosi  out  1  SHALL be the serial data output to the slave.
REQ-015 sck  out  1  SHALL be the serial clock.
REQ-016 cs_n  out  NUM_CS  SHALL be the active-low chip selects, one per slave.
REQ-017 busy  out  1  SHALL be high while a transfer is in progress.
REQ-018 done  out  1  SHALL be a one-cycle completion pulse.
REQ-019 data_out  out  DATA_W  SHALL be the received word.

Function
REQ-020 The block SHALL latch data_in, cs_sel, cpol, cpha, lsb_first and clk_div on the accepting start edge and SHALL ignore input changes until the next acceptance.
REQ-021 The state machine SHALL have states IDLE, SETUP, SHIFT and HOLD, with transitions IDLE->SETUP on accepted start, SETUP->SHIFT after H cycles, SHIFT->HOLD after 2*DATA_W*H cycles, and HOLD->IDLE after H cycles.
REQ-022 Starting the cycle after acceptance, cs_n[cs_sel] SHALL go low and busy SHALL go high; both SHALL hold until the cycle after HOLD ends.
REQ-023 If cs_sel >= NUM_CS, the transfer SHALL run with all cs_n bits held high (no slave selected).
REQ-024 sck SHALL equal the latched cpol in IDLE, SETUP and HOLD, and SHALL toggle every H cycles in SHIFT, giving exactly DATA_W pulses.
REQ-025 With cpha=0, the first bit SHALL be on mosi at SETUP entry; miso SHALL be sampled on each leading edge; mosi SHALL advance on each trailing edge, except after the last bit.
REQ-026 With cpha=1, mosi SHALL update on each leading edge and miso SHALL be sampled on each trailing edge.
REQ-027 Sampled bits SHALL be assembled in the same order as transmission, so that data_out holds the slave word in natural bit order.
REQ-028 On the cycle after HOLD ends, done SHALL pulse for 1 cycle, busy SHALL fall and data_out SHALL update; data_out SHALL then hold until the next done.
REQ-029 A start present in the same cycle as done or busy SHALL be ignored; start is accepted no earlier than the cycle after done.
REQ-030 Total latency from the accepting start edge to done SHALL be (2*DATA_W+2)*H+1 cycles.
REQ-031 mosi SHALL be 0 in IDLE.
REQ-032 The divider counter SHALL be DIV_W bits wide and SHALL reload without overflow at clk_div = all-ones.

Reset
REQ-033 Asserting reset at any time, including mid-transfer, SHALL immediately force: sck=0, mosi=0, cs_n=all ones, busy=0, done=0, data_out=0, state=IDLE, and all counters to 0.
REQ-034 After reset deasserts, the first start SHALL be accepted normally, with no residue from an aborted transfer.

Structure
REQ-035 A shared package spi_pkg SHALL hold the state enumeration, the state encoding width and the SPI mode constants MODE0..MODE3.
REQ-036 The half-period tick generator SHALL be a separate sub-module, spi_clk_div, which takes clk, reset, enable and clk_div and produces a one-cycle tick every H cycles.

Verification
REQ-037 Mode 0, MSB first, DATA_W=8, clk_div=1, data_in=0xA5, loopback miso=mosi -> mosi shows 1,0,1,0,0,1,0,1; data_out=0xA5; done arrives 37 cycles after start.
REQ-038 Mode 3, LSB first, data_in=0x3C, slave returns 0xC3 -> mosi shows 0,0,1,1,1,1,0,0; data_out=0xC3; sck idles high.
REQ-039 cs_sel=2 with NUM_CS=4 -> only cs_n[2] goes low; cs_sel=5 with NUM_CS=8 -> only cs_n[5] goes low; cs_sel=5 with NUM_CS=4 is not representable and is not a test case.
REQ-040 start pulsed mid-transfer and again in the done cycle -> both ignored; exactly one done pulse is produced.
REQ-041 reset asserted at bit 4 of a transfer -> cs_n=all ones and sck=0 in the same cycle; the next start with data_in=0x0F completes with loopback data_out=0x0F.
REQ-042 clk_div=0 (H=1) with data_in=0xFF -> sck toggles every cycle, 8 pulses; done arrives 19 cycles after start.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and the {cpol,cpha} mode constants.
package spi_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Mode constants are packed as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period tick generator: a one-cycle tick every clk_div+1 cycles while enabled.
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] clk_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    assign tick = enable && (cnt_q == clk_div);

    // Reload on match rather than on wrap, so clk_div = all-ones never overflows
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (!enable || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_modes.sv
// SPI master supporting all four CPOL/CPHA modes, selectable bit order and per-transfer
// chip select; every transfer setting is latched when start is accepted.
module spi_master_modes
    import spi_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NUM_CS = 4,
    parameter  int DIV_W  = 8,
    localparam int CSW    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CSW-1:0]    cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic [NUM_CS-1:0] cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out
);

    localparam int BW = $clog2(DATA_W);
    localparam int EW = BW + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    state_t            state_q;
    logic [DATA_W-1:0] data_q, rx_q, dout_q;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic [DIV_W-1:0]  div_q;
    logic [EW-1:0]     edge_q;
    logic              cpol_q, cpha_q, lsb_q;
    logic              sck_q, mosi_q, busy_q, done_q, fin_q;
    logic              tick;
    logic [BW-1:0]     half;

    spi_clk_div #(.DIV_W(DIV_W)) u_div (
        .clk     (clk),
        .reset   (reset),
        .enable  (state_q != IDLE),
        .clk_div (div_q),
        .tick    (tick)
    );

    // Edge count / 2 is the index of the bit currently on the wire
    assign half = edge_q[EW-1:1];

    function automatic logic [BW-1:0] pos(input logic [BW-1:0] b, input logic lsb);
        return lsb ? b : BW'(DATA_W - 1) - b;
    endfunction

    // Out-of-range cs_sel matches no bit, leaving every select high
    always_comb begin
        cs_n_d = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (32'(cs_sel) == i) cs_n_d[i] = 1'b0;
        end
    end

    // fin_q marks the extra IDLE cycle after HOLD so done/busy/cs_n land one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            cs_n_q  <= '1;
            div_q   <= '0;
            edge_q  <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (fin_q) begin
                fin_q  <= 1'b0;
                done_q <= 1'b1;
                busy_q <= 1'b0;
                cs_n_q <= '1;
                dout_q <= rx_q;
            end
            case (state_q)
                IDLE: begin
                    if (start && !busy_q && !done_q) begin
                        state_q <= SETUP;
                        data_q  <= data_in;
                        rx_q    <= '0;
                        cs_n_q  <= cs_n_d;
                        div_q   <= clk_div;
                        cpol_q  <= cpol;
                        cpha_q  <= cpha;
                        lsb_q   <= lsb_first;
                        sck_q   <= cpol;
                        mosi_q  <= lsb_first ? data_in[0] : data_in[DATA_W-1];
                        edge_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (tick) state_q <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        sck_q <= ~sck_q;
                        if (!edge_q[0]) begin
                            if (!cpha_q) rx_q[pos(half, lsb_q)] <= miso;
                            else if (edge_q != '0) mosi_q <= data_q[pos(half, lsb_q)];
                        end else begin
                            if (cpha_q) rx_q[pos(half, lsb_q)] <= miso;
                            else if (edge_q != LAST_EDGE) mosi_q <= data_q[pos(half + BW'(1), lsb_q)];
                        end
                        if (edge_q == LAST_EDGE) begin
                            edge_q  <= '0;
                            state_q <= HOLD;
                        end else begin
                            edge_q <= edge_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state_q <= IDLE;
                        mosi_q  <= 1'b0;
                        fin_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mosi     = mosi_q;
    assign sck      = sck_q;
    assign cs_n     = cs_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = dout_q;

endmodule

// File: tb/tb_spi_master_modes.sv
// Scoreboard bench for spi_master_modes: directed transfers push expectations, a
// negedge monitor tracks the SPI wires and checks each completed transfer on done.
module tb_spi_master_modes;
    import spi_pkg::*;

    localparam int DATA_W = 8;

    typedef struct {
        logic [7:0] data;
        int         lat;
        logic [7:0] seq;
        logic [3:0] cs;
        logic [7:0] cs8;
        logic       idle;
    } exp_t;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [7:0] data_in = '0, clk_div = '0;
    logic [1:0] cs_sel = '0;
    logic [2:0] cs_sel8 = '0;
    logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic       miso, mosi, sck, busy, done;
    logic [3:0] cs_n;
    logic [7:0] data_out;
    logic       mosi8, sck8, busy8, done8;
    logic [7:0] cs_n8, data_out8;

    exp_t       q[$];
    int         cyc = 0, t_acc = 0, pulses = 0, slave_idx = 0, done_cnt = 0;
    int         n_checks = 0, n_pass = 0;
    logic [7:0] cap = '0, slave_seq = '0, cs8_and = '1;
    logic [3:0] cs_and = '1;
    logic       prev_busy = 1'b0, sck_prev = 1'b0, lead;
    logic       m_cpol = 1'b0, m_cpha = 1'b0, m_lb = 1'b1;

    assign miso = m_lb ? mosi : slave_seq[3'(DATA_W - 1 - slave_idx)];

    spi_master_modes #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in), .cs_sel(cs_sel),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div), .miso(miso),
        .mosi(mosi), .sck(sck), .cs_n(cs_n), .busy(busy), .done(done), .data_out(data_out)
    );

    spi_master_modes #(.DATA_W(8), .NUM_CS(8), .DIV_W(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in), .cs_sel(cs_sel8),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div), .miso(miso),
        .mosi(mosi8), .sck(sck8), .cs_n(cs_n8), .busy(busy8), .done(done8), .data_out(data_out8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Monitor: only counts sck edges inside a transfer, so the idle-level change at accept is ignored
    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
            sck_prev  = sck;
        end else begin
            if (busy && !prev_busy) begin
                t_acc = cyc; cap = '0; pulses = 0; cs_and = '1; cs8_and = '1; slave_idx = 0;
            end else if (busy && sck != sck_prev) begin
                lead = (sck != m_cpol);
                if (lead) pulses++;
                if (lead != m_cpha) begin
                    cap = {cap[6:0], mosi};
                    if (slave_idx < DATA_W) slave_idx++;
                end
            end
            if (busy) begin
                cs_and  = cs_and & cs_n;
                cs8_and = cs8_and & cs_n8;
            end
            sck_prev = sck;
            if (done) begin
                exp_t e;
                done_cnt++;
                chk("done_has_expectation", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("data_out", data_out, e.data);
                    chk("latency", cyc - t_acc, e.lat);
                    chk("mosi_bits", cap, e.seq);
                    chk("sck_pulses", pulses, DATA_W);
                    chk("cs_n_active", cs_and, e.cs);
                    chk("cs_n8_active", cs8_and, e.cs8);
                    chk("sck_idle", sck, e.idle);
                    chk("cs_n_release", cs_n, 4'hF);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic run(input logic [7:0] d, input logic [1:0] sel, input logic [2:0] sel8,
                       input logic [1:0] mode, input logic lsb, input logic [7:0] div,
                       input logic lb, input logic [7:0] sseq, input logic [7:0] exp_data,
                       input int lat, input logic [7:0] seq, input logic [3:0] cs,
                       input logic [7:0] cs8, input logic pmid, input logic pdone);
        exp_t e;
        bit   got;
        e = '{exp_data, lat, seq, cs, cs8, mode[1]};
        q.push_back(e);
        @(posedge clk); #1;
        m_cpol = mode[1]; m_cpha = mode[0]; m_lb = lb; slave_seq = sseq;
        data_in = d; cs_sel = sel; cs_sel8 = sel8; {cpol, cpha} = mode;
        lsb_first = lsb; clk_div = div; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble every input after acceptance; the transfer must use the latched copy
        data_in = ~d; cs_sel = ~sel; cs_sel8 = ~sel8; cpol = ~mode[1]; cpha = ~mode[0];
        lsb_first = ~lsb; clk_div = 8'h07;
        got = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            start = pmid && (i == 10);
            if (done) begin got = 1'b1; break; end
        end
        chk("done_timeout", got, 1);
        start = 1'b0;
        if (pdone) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("start_in_done_ignored", busy, 0);
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", cs_n, 4'hF);
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data_out", data_out, 0);
        reset = 1'b0;

        //   data   sel sel8 mode  lsb div    lb sseq   expd   lat   seq    cs       cs8    mid done
        run(8'hA5, 2, 5, MODE0, 0, 8'd1,   1, 8'h00, 8'hA5, 37,   8'hA5, 4'b1011, 8'hDF, 0, 0);
        run(8'h3C, 0, 5, MODE3, 1, 8'd1,   0, 8'hC3, 8'hC3, 37,   8'h3C, 4'b1110, 8'hDF, 0, 0);
        run(8'h5A, 3, 7, MODE1, 0, 8'hFF,  1, 8'h00, 8'h5A, 4609, 8'h5A, 4'b0111, 8'h7F, 0, 0);
        run(8'h96, 1, 0, MODE2, 1, 8'd2,   0, 8'hD4, 8'h2B, 55,   8'h69, 4'b1101, 8'hFE, 0, 0);
        run(8'hFF, 0, 1, MODE0, 0, 8'd0,   1, 8'h00, 8'hFF, 19,   8'hFF, 4'b1110, 8'hFD, 0, 0);
        run(8'h81, 1, 3, MODE0, 0, 8'd1,   1, 8'h00, 8'h81, 37,   8'h81, 4'b1101, 8'hF7, 1, 1);

        // Abort a mode-2 transfer around bit 4 with an asynchronous reset
        @(posedge clk); #1;
        m_cpol = 1'b1; m_cpha = 1'b0; m_lb = 1'b1;
        data_in = 8'hF0; cs_sel = 2'd2; cs_sel8 = 3'd5; {cpol, cpha} = MODE2;
        lsb_first = 1'b0; clk_div = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (18) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("abort_cs_n", cs_n, 4'hF);
        chk("abort_cs_n8", cs_n8, 8'hFF);
        chk("abort_sck", sck, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_data_out", data_out, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run(8'h0F, 2, 5, MODE0, 0, 8'd1,   1, 8'h00, 8'h0F, 37,   8'h0F, 4'b1011, 8'hDF, 0, 0);

        repeat (5) @(posedge clk);
        chk("done_count", done_cnt, 7);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
